gfx_zbuf_reader: RTL and testbench
==================================

GFX_ZBUF_READER -- requirements
Module: gfx_zbuf_reader

Interface
REQ-001 SHALL have parameter MDW, default 256: memory data width in bits (power of two, >=32).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum wishbone wait cycles before abort (1..65535).
REQ-003 SHALL use one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- z_request_i  in  1  depth read request, level, held until z_ack_o
- z_addr_i  in  32  byte address of requested depth word
- z_sel_i  in  32  byte selects from requester (ignored; full line fetched)
- z_ack_o  out  1  single-cycle completion pulse
- z_data_o  out  MDW  returned memory line
- busy_o  out  1  reader not idle
- invalidate_i  in  1  drop cached line (z-buffer written elsewhere)
- err_clr_i  in  1  clears err_o
- err_o  out  1  sticky bus error/timeout flag
- m_cyc_o, m_stb_o  out  1 each  wishbone cycle/strobe
- m_we_o  out  1  constant 0
- m_adr_o  out  32  line-aligned byte address
- m_sel_o  out  MDW/8  all ones during a cycle
- m_dat_i  in  MDW  read data
- m_ack_i, m_err_i  in  1 each  wishbone ack/error

Function
REQ-005 SHALL align addresses: line = z_addr_i with low log2(MDW/8) bits forced to 0.
REQ-006 SHALL hold a one-line cache: valid bit, 32-bit tag, MDW-bit data.
REQ-007 SHALL implement states IDLE, BUS, ACK, DROP; busy_o = (state != IDLE).
REQ-008 IDLE: z_request_i=1 and hit (valid, tag==line, invalidate_i=0) -> ACK with z_data_o loaded from cache; z_ack_o high in the next cycle (hit latency 1).
REQ-009 IDLE: z_request_i=1 and miss -> BUS; m_cyc_o=m_stb_o=1, m_adr_o=line, m_sel_o all ones, from the next cycle.
REQ-010 BUS: m_ack_i=1 -> z_data_o<=m_dat_i, cache tag/data updated and valid set, cyc/stb dropped the following cycle, -> ACK.
REQ-011 BUS: m_err_i=1 (priority over m_ack_i) or wait counter reaching TIMEOUT -> z_data_o<=0, err_o<=1, cache valid cleared, cyc/stb dropped, -> ACK.
REQ-012 The wait counter SHALL be 16 bits, cleared on BUS entry, incremented each BUS cycle without ack/err.
REQ-013 ACK: z_ack_o=1 for exactly this cycle; -> DROP unconditionally.
REQ-014 DROP: -> IDLE when z_request_i=0; otherwise stay (no new fetch for a held request).
REQ-015 invalidate_i=1 SHALL clear valid in any state; if asserted during BUS, the fill in progress SHALL NOT set valid.
REQ-016 invalidate_i coincident with an IDLE request SHALL force a miss.
REQ-017 err_clr_i SHALL clear err_o unless a new error is set the same cycle (set wins).
REQ-018 z_data_o SHALL be stable from ACK until the next ACK.
REQ-019 m_cyc_o and m_stb_o SHALL be asserted only in BUS, and always together.

Reset
REQ-020 rst_i SHALL immediately force state IDLE; m_cyc_o, m_stb_o, z_ack_o, err_o, busy_o, valid, and the wait counter to 0; z_data_o to 0; m_adr_o to 0.
REQ-021 Reset during BUS SHALL abandon the cycle at once; a late m_ack_i after reset SHALL be ignored.

Verification
REQ-022 Miss: request addr 0x0000_1234 (MDW=256) -> m_adr_o=0x0000_1220, slave acks after 3 cycles with pattern P -> z_ack_o one cycle, z_data_o=P, err_o=0.
REQ-023 Hit: repeat request to 0x0000_1238 after DROP->IDLE -> no m_cyc_o, z_ack_o 1 cycle after request, z_data_o=P.
REQ-024 Invalidate: pulse invalidate_i during a BUS fill to 0x2000, then request 0x2000 -> second wishbone cycle issued.
REQ-025 Timeout: TIMEOUT=8, slave never acks -> cyc dropped after 8 wait cycles, z_ack_o pulse, z_data_o=0, err_o=1 until err_clr_i.
REQ-026 Error vs ack: m_err_i and m_ack_i same cycle -> error path, cache not valid, err_o=1.
REQ-027 Reset mid-BUS: assert rst_i 2 cycles into BUS -> m_cyc_o=0 same cycle, busy_o=0, no z_ack_o after release.

Source files
------------

// File: rtl/gfx_zbuf_reader_if.sv
// Requester and wishbone-master signal bundle for the depth-buffer line reader.
// Signal names keep their direction suffixes so they read the same on both sides.
interface gfx_zbuf_reader_if #(
    parameter int unsigned MDW = 256
);
    logic             z_request_i;
    logic [31:0]      z_addr_i;
    logic [31:0]      z_sel_i;
    logic             z_ack_o;
    logic [MDW-1:0]   z_data_o;
    logic             busy_o;
    logic             invalidate_i;
    logic             err_clr_i;
    logic             err_o;
    logic             m_cyc_o;
    logic             m_stb_o;
    logic             m_we_o;
    logic [31:0]      m_adr_o;
    logic [MDW/8-1:0] m_sel_o;
    logic [MDW-1:0]   m_dat_i;
    logic             m_ack_i;
    logic             m_err_i;

    modport master (
        input  z_request_i, z_addr_i, z_sel_i, invalidate_i, err_clr_i,
        input  m_dat_i, m_ack_i, m_err_i,
        output z_ack_o, z_data_o, busy_o, err_o,
        output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o
    );

    modport slave (
        output z_request_i, z_addr_i, z_sel_i, invalidate_i, err_clr_i,
        output m_dat_i, m_ack_i, m_err_i,
        input  z_ack_o, z_data_o, busy_o, err_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o
    );
endinterface

// File: rtl/gfx_zbuf_reader.sv
// Depth-buffer reader with a single-line cache, fetching whole memory lines
// over a wishbone read master with error/timeout abort.
module gfx_zbuf_reader #(
    parameter int unsigned MDW     = 256,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    gfx_zbuf_reader_if.master bus
);
    localparam int unsigned CNT_W    = 16;
    localparam logic [31:0] OFF_MASK = 32'(MDW / 8 - 1);

    typedef enum logic [1:0] {IDLE, BUS, ACK, DROP} state_t;

    state_t             state_q, state_d;
    logic [MDW-1:0]     z_data_q;
    logic [MDW-1:0]     line_data_q;
    logic [31:0]        tag_q;
    logic [31:0]        adr_q;
    logic [CNT_W-1:0]   wait_q;
    logic               valid_q;
    logic               fill_ok_q;
    logic               err_q;

    logic [31:0]        line_c;
    logic               hit_c;
    logic               fault_c;
    logic               unused_sel;

    assign line_c     = bus.z_addr_i & ~OFF_MASK;
    assign hit_c      = valid_q && (tag_q == line_c) && !bus.invalidate_i;
    // Error wins over ack; timeout fires once TIMEOUT empty wait cycles have elapsed.
    assign fault_c    = bus.m_err_i || (wait_q == CNT_W'(TIMEOUT));
    assign unused_sel = ^bus.z_sel_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.z_request_i) state_d = hit_c ? ACK : BUS;
            BUS:  if (fault_c || bus.m_ack_i) state_d = ACK;
            ACK:  state_d = DROP;
            DROP: if (!bus.z_request_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: cache, returned line, wait counter and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            z_data_q    <= '0;
            line_data_q <= '0;
            tag_q       <= '0;
            adr_q       <= '0;
            wait_q      <= '0;
            valid_q     <= 1'b0;
            fill_ok_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (bus.err_clr_i) err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.z_request_i && hit_c) begin
                        z_data_q <= line_data_q;
                    end else if (bus.z_request_i) begin
                        adr_q     <= line_c;
                        wait_q    <= '0;
                        fill_ok_q <= 1'b1;
                    end
                end
                BUS: begin
                    if (fault_c) begin
                        z_data_q <= '0;
                        valid_q  <= 1'b0;
                        err_q    <= 1'b1;
                    end else if (bus.m_ack_i) begin
                        z_data_q    <= bus.m_dat_i;
                        line_data_q <= bus.m_dat_i;
                        tag_q       <= adr_q;
                        valid_q     <= fill_ok_q;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                    if (bus.invalidate_i) fill_ok_q <= 1'b0;
                end
                default: ;
            endcase
            // An invalidate in the same cycle as a fill still leaves the line invalid.
            if (bus.invalidate_i) valid_q <= 1'b0;
        end
    end

    assign bus.z_ack_o  = (state_q == ACK);
    assign bus.z_data_o = z_data_q;
    assign bus.busy_o   = (state_q != IDLE);
    assign bus.err_o    = err_q;
    assign bus.m_cyc_o  = (state_q == BUS);
    assign bus.m_stb_o  = (state_q == BUS);
    assign bus.m_we_o   = 1'b0;
    assign bus.m_adr_o  = adr_q;
    assign bus.m_sel_o  = '1;
endmodule

// File: tb/tb_gfx_zbuf_reader.sv
// Directed vector bench for gfx_zbuf_reader: table of requests against a
// scripted wishbone slave, plus reset-mid-cycle sequence.
module tb_gfx_zbuf_reader;
    localparam int unsigned MDW     = 256;
    localparam int unsigned TIMEOUT = 8;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    localparam logic [255:0] P1 = {8{32'h1111_A001}};
    localparam logic [255:0] P2 = {8{32'h2222_B002}};
    localparam logic [255:0] P3 = {8{32'h3333_C003}};
    localparam logic [255:0] P4 = {8{32'h4444_D004}};
    localparam logic [255:0] P5 = {8{32'h5555_E005}};
    localparam logic [255:0] P6 = {8{32'h6666_F006}};
    localparam logic [255:0] P7 = {8{32'h7777_0107}};
    localparam logic [255:0] P8 = {8{32'h8888_0208}};
    localparam logic [255:0] P9 = {8{32'h9999_0309}};
    localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};

    typedef struct {
        logic [31:0]  addr;
        int           kind;
        int           lat;
        int           inv;      // 0 none, 1 with request, 2 during bus cycle
        bit           clr;
        int           exp_cyc;
        logic [31:0]  exp_adr;
        int           exp_lat;
        logic [255:0] exp_data;
        bit           exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int           slave_kind;
    int           slave_lat;
    logic [255:0] slave_data;
    bit           late_ack;
    int           age;

    vec_t vecs[16];

    gfx_zbuf_reader_if #(.MDW(MDW)) zif ();

    gfx_zbuf_reader #(.MDW(MDW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (zif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scripted wishbone slave: responds on the lat-th cycle of an open cycle.
    initial begin
        zif.m_ack_i = 1'b0;
        zif.m_err_i = 1'b0;
        zif.m_dat_i = '0;
        age = 0;
        forever begin
            @(negedge clk);
            if (zif.m_cyc_o === 1'b1) age++;
            else age = 0;
            zif.m_ack_i = late_ack;
            zif.m_err_i = 1'b0;
            zif.m_dat_i = slave_data;
            if (zif.m_cyc_o === 1'b1 && age == slave_lat) begin
                case (slave_kind)
                    K_ACK:  zif.m_ack_i = 1'b1;
                    K_ERR:  zif.m_err_i = 1'b1;
                    K_BOTH: begin zif.m_ack_i = 1'b1; zif.m_err_i = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    task automatic run_row(input vec_t v, input int idx);
        int           lat;
        int           cyc_n;
        int           acks;
        int           sig_bad;
        bit           done;
        logic [31:0]  adr;
        logic [255:0] dat;
        slave_kind = v.kind;
        slave_lat  = v.lat;
        slave_data = (v.kind == K_ACK) ? v.exp_data : JUNK;
        if (v.clr) begin
            @(negedge clk); zif.err_clr_i = 1'b1;
            @(negedge clk); zif.err_clr_i = 1'b0;
        end
        @(negedge clk);
        zif.z_request_i  = 1'b1;
        zif.z_addr_i     = v.addr;
        zif.z_sel_i      = $urandom;
        zif.invalidate_i = (v.inv == 1);
        lat = 0; cyc_n = 0; acks = 0; sig_bad = 0; done = 1'b0;
        adr = '0; dat = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (zif.m_stb_o !== zif.m_cyc_o || zif.m_we_o !== 1'b0) sig_bad++;
            if (zif.m_cyc_o === 1'b1) begin
                cyc_n++;
                adr = zif.m_adr_o;
                if (zif.m_sel_o !== {(MDW/8){1'b1}}) sig_bad++;
            end
            if (zif.z_ack_o === 1'b1) begin
                acks++;
                lat = c;
                dat = zif.z_data_o;
                done = 1'b1;
            end
            if (c == 1 && v.inv == 2) begin
                @(negedge clk);
                zif.invalidate_i = 1'b1;
            end else begin
                zif.invalidate_i = 1'b0;
            end
            if (done) break;
        end
        check($sformatf("r%0d ack_seen", idx), 256'(acks), 256'(1));
        check($sformatf("r%0d latency", idx), 256'(lat), 256'(v.exp_lat));
        check($sformatf("r%0d cyc_cycles", idx), 256'(cyc_n), 256'(v.exp_cyc));
        if (v.exp_cyc > 0) check($sformatf("r%0d m_adr", idx), 256'(adr), 256'(v.exp_adr));
        check($sformatf("r%0d z_data", idx), dat, v.exp_data);
        check($sformatf("r%0d err", idx), 256'(zif.err_o), 256'(v.exp_err));
        // Held request: no second ack, data held, still busy.
        @(posedge clk); #1;
        check($sformatf("r%0d drop_state", idx),
              256'({zif.z_ack_o, zif.busy_o, zif.m_cyc_o}), 256'(3'b010));
        check($sformatf("r%0d data_stable", idx), zif.z_data_o, dat);
        @(negedge clk);
        zif.z_request_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("r%0d idle_busy", idx), 256'(zif.busy_o), 256'(0));
        check($sformatf("r%0d bus_signals", idx), 256'(sig_bad), 256'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        late_ack = 1'b0;
        slave_kind = K_NONE;
        slave_lat = 0;
        slave_data = JUNK;
        zif.z_request_i  = 1'b0;
        zif.z_addr_i     = '0;
        zif.z_sel_i      = '0;
        zif.invalidate_i = 1'b0;
        zif.err_clr_i    = 1'b0;

        //           addr          kind    lat inv clr cyc adr           lat data err
        vecs[0]  = '{32'h0000_1234, K_ACK,  3, 0, 0, 3, 32'h0000_1220, 4,  P1, 1'b0};
        vecs[1]  = '{32'h0000_1238, K_ACK,  1, 0, 0, 0, 32'h0,         1,  P1, 1'b0};
        vecs[2]  = '{32'h0000_123F, K_ACK,  1, 0, 0, 0, 32'h0,         1,  P1, 1'b0};
        vecs[3]  = '{32'h0000_1240, K_ACK,  1, 0, 0, 1, 32'h0000_1240, 2,  P2, 1'b0};
        vecs[4]  = '{32'h0000_1220, K_ACK,  2, 0, 0, 2, 32'h0000_1220, 3,  P3, 1'b0};
        vecs[5]  = '{32'h0000_3000, K_BOTH, 2, 0, 0, 2, 32'h0000_3000, 3,  '0, 1'b1};
        vecs[6]  = '{32'h0000_3004, K_ACK,  1, 0, 1, 1, 32'h0000_3000, 2,  P4, 1'b0};
        vecs[7]  = '{32'h0000_5000, K_NONE, 0, 0, 0, 9, 32'h0000_5000, 10, '0, 1'b1};
        vecs[8]  = '{32'h0000_3010, K_ACK,  1, 0, 1, 1, 32'h0000_3000, 2,  P5, 1'b0};
        vecs[9]  = '{32'h0000_301C, K_ACK,  1, 0, 0, 0, 32'h0,         1,  P5, 1'b0};
        vecs[10] = '{32'h0000_5000, K_ERR,  1, 0, 0, 1, 32'h0000_5000, 2,  '0, 1'b1};
        vecs[11] = '{32'h0000_2000, K_ACK,  3, 2, 1, 3, 32'h0000_2000, 4,  P6, 1'b0};
        vecs[12] = '{32'h0000_2000, K_ACK,  1, 0, 0, 1, 32'h0000_2000, 2,  P7, 1'b0};
        vecs[13] = '{32'h0000_2010, K_ACK,  1, 0, 0, 0, 32'h0,         1,  P7, 1'b0};
        vecs[14] = '{32'h0000_2010, K_ACK,  1, 1, 0, 1, 32'h0000_2000, 2,  P8, 1'b0};
        vecs[15] = '{32'h0000_2004, K_ACK,  1, 0, 0, 0, 32'h0,         1,  P8, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_in_reset",
              256'({zif.m_cyc_o, zif.m_stb_o, zif.z_ack_o, zif.err_o, zif.busy_o}), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs",
              256'({zif.m_cyc_o, zif.m_stb_o, zif.z_ack_o, zif.err_o, zif.busy_o}), 256'(0));
        check("reset_z_data", zif.z_data_o, '0);
        check("reset_m_adr", 256'(zif.m_adr_o), 256'(0));

        for (int i = 0; i < 16; i++) run_row(vecs[i], i);

        // Reset two cycles into a bus cycle, with a late ack around release.
        begin
            int bad;
            slave_kind = K_NONE;
            slave_data = JUNK;
            @(negedge clk);
            zif.z_request_i = 1'b1;
            zif.z_addr_i    = 32'h0000_7000;
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("pre_reset_cyc", 256'({zif.m_cyc_o, zif.busy_o}), 256'(2'b11));
            @(negedge clk);
            rst = 1'b1;
            zif.z_request_i = 1'b0;
            #1;
            check("mid_bus_reset_cyc",
                  256'({zif.m_cyc_o, zif.m_stb_o, zif.busy_o, zif.z_ack_o}), 256'(0));
            late_ack = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            late_ack = 1'b0;
            bad = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (zif.z_ack_o !== 1'b0 || zif.m_cyc_o !== 1'b0 || zif.busy_o !== 1'b0) bad++;
            end
            check("post_reset_quiet", 256'(bad), 256'(0));
            check("post_reset_err", 256'(zif.err_o), 256'(0));
            check("post_reset_data", zif.z_data_o, '0);
        end

        // Cache must be empty after reset: previously cached line misses.
        run_row('{32'h0000_2004, K_ACK, 1, 0, 0, 1, 32'h0000_2000, 2, P9, 1'b0}, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
